// File: rtl/commit_unit_pkg.sv
// ---------------------------------------------------------------------------
// commit_unit_pkg : shared core types for the in-order retirement stage
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package commit_unit_pkg;

  localparam int BUF_SIZE_LOG = 4;

  typedef logic bool;
  localparam bool true  = 1'b1;
  localparam bool false = 1'b0;

  typedef logic [BUF_SIZE_LOG-1:0] tag_t;
  typedef logic [5:0]              spec_tag_t;

  typedef enum logic [1:0] {S_NOT_USED, S_ISSUED, S_ADDR_GENERATED, S_EXECUTED} state_t;
  typedef enum logic [1:0] {ALU, BRANCH, LOAD, STORE} unit_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD} ldst_mode_t;

  typedef struct packed {
    state_t      e_state;
    unit_t       Unit;
    logic [4:0]  Dest;
    logic [31:0] result;
    tag_t        tag;
    spec_tag_t   speculative_tag;
    logic [31:0] A;
    logic [31:0] Vk;
    ldst_mode_t  rwmm;
  } entry_t;

  // Executed and no longer under any unresolved branch.
  function automatic bool is_eligible(entry_t e);
    return (e.e_state == S_EXECUTED) && (e.speculative_tag == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_unit_store_port.sv
// ---------------------------------------------------------------------------
// store_port : request/acknowledge FSM and registered payload for committed stores
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_port
  import commit_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  ldst_mode_t  mode,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output ldst_mode_t  mem_mode,
  output logic        store_done
);

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} fsm_t;

  fsm_t st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mode  <= BYTE;
    end else begin
      case (st)
        ST_IDLE: if (issue) begin
          st        <= ST_WAIT;
          mem_req   <= 1'b1;
          mem_addr  <= addr;
          mem_wdata <= wdata;
          mem_mode  <= mode;
        end
        ST_WAIT: if (mem_ack) begin
          st      <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // An ack seen while idle is stray and must not retire anything.
  assign store_done = (st == ST_WAIT) && mem_ack;

endmodule

`default_nettype wire

// File: rtl/commit_unit.sv
// ---------------------------------------------------------------------------
// commit_unit : retires up to two head entries per cycle, one store at most
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int BUF_SIZE_LOG = commit_unit_pkg::BUF_SIZE_LOG,
  parameter int INSTRET_W    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  entry_t [1:0]                 head,
  output logic   [1:0]                 rf_we,
  output logic   [1:0][4:0]            rf_addr,
  output logic   [1:0][31:0]           rf_data,
  output logic   [1:0][BUF_SIZE_LOG-1:0] commit_tag,
  output bool    [1:0]                 is_really_commited,
  output bool    [1:0]                 is_commited_store,
  output logic                         mem_req,
  output logic   [31:0]                mem_addr,
  output logic   [31:0]                mem_wdata,
  output ldst_mode_t                   mem_mode,
  input  logic                         mem_ack,
  output logic   [INSTRET_W-1:0]       instret
);

  logic [1:0] elig;
  logic [1:0] is_store;
  logic [1:0] retire;
  logic       store_done;

  for (genvar k = 0; k < 2; k++) begin : g_slot
    assign elig[k]               = is_eligible(head[k]);
    assign is_store[k]           = (head[k].Unit == STORE);
    assign rf_we[k]              = retire[k] && !is_store[k] && (head[k].Dest != 5'd0);
    assign rf_addr[k]            = head[k].Dest;
    assign rf_data[k]            = head[k].result;
    assign commit_tag[k]         = retire[k] ? BUF_SIZE_LOG'(head[k].tag) : '0;
    assign is_really_commited[k] = retire[k];
    assign is_commited_store[k]  = retire[k] && is_store[k];
  end

  // Stores only ever leave from slot 0, so slot 1 retirement needs a non-store.
  assign retire[0] = elig[0] && (!is_store[0] || store_done);
  assign retire[1] = retire[0] && elig[1] && !is_store[1];

  store_port u_store_port (
    .clk        (clk),
    .reset      (reset),
    .issue      (elig[0] && is_store[0]),
    .addr       (head[0].A),
    .wdata      (head[0].Vk),
    .mode       (head[0].rwmm),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mode   (mem_mode),
    .store_done (store_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) instret <= '0;
    else        instret <= instret + INSTRET_W'(retire[0]) + INSTRET_W'(retire[1]);
  end

  logic unused_slot1;
  assign unused_slot1 = ^{head[1].A, head[1].Vk, head[1].rwmm};

endmodule

`default_nettype wire

// File: tb/tb_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_commit_unit : directed stimulus with queued expectations and a negedge monitor
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_commit_unit;
  import commit_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  entry_t [1:0]         head;
  logic                 mem_ack = 1'b0;
  logic   [1:0]         rf_we;
  logic   [1:0][4:0]    rf_addr;
  logic   [1:0][31:0]   rf_data;
  logic   [1:0][3:0]    commit_tag;
  bool    [1:0]         rtr, sto;
  logic                 mem_req;
  logic   [31:0]        mem_addr, mem_wdata;
  ldst_mode_t           mem_mode;
  logic   [63:0]        instret;

  commit_unit #(.BUF_SIZE_LOG(4), .INSTRET_W(64)) dut (
    .clk(clk), .reset(reset), .head(head),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .commit_tag(commit_tag),
    .is_really_commited(rtr), .is_commited_store(sto),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .mem_ack(mem_ack), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           nm;
    logic [1:0]      retire, store, we;
    logic [1:0][4:0] addr;
    logic [1:0][31:0] data;
    logic [1:0][3:0] tag;
    logic            req;
    bit              chk_pay;
    logic [31:0]     maddr, mwdata;
    ldst_mode_t      mmode;
    logic [63:0]     ir;
    bit              chk_r7;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf [32];
  logic [31:0] pa = '0, pw = '0;
  ldst_mode_t  pm = BYTE;

  task automatic chk(string nm, string what, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, plus a register-file model fed by the write ports.
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk(e.nm, "retire", 64'(rtr), 64'(e.retire));
        chk(e.nm, "store", 64'(sto), 64'(e.store));
        chk(e.nm, "rf_we", 64'(rf_we), 64'(e.we));
        for (int k = 0; k < 2; k++) if (e.we[k]) begin
          chk(e.nm, "rf_addr", 64'(rf_addr[k]), 64'(e.addr[k]));
          chk(e.nm, "rf_data", 64'(rf_data[k]), 64'(e.data[k]));
        end
        chk(e.nm, "commit_tag", 64'(commit_tag), 64'(e.tag));
        chk(e.nm, "mem_req", 64'(mem_req), 64'(e.req));
        if (e.chk_pay) begin
          chk(e.nm, "mem_addr", 64'(mem_addr), 64'(e.maddr));
          chk(e.nm, "mem_wdata", 64'(mem_wdata), 64'(e.mwdata));
          chk(e.nm, "mem_mode", 64'(mem_mode), 64'(e.mmode));
        end
        chk(e.nm, "instret", instret, e.ir);
        if (e.chk_r7) chk(e.nm, "r7", 64'(rf[7]), 64'd2);
      end
      for (int k = 0; k < 2; k++) if (rf_we[k] === 1'b1) rf[rf_addr[k]] = rf_data[k];
    end
  end

  function automatic entry_t mk(state_t s, unit_t u, logic [4:0] d, logic [31:0] r,
                                logic [3:0] t, logic [5:0] sp, logic [31:0] a,
                                logic [31:0] v, ldst_mode_t m);
    entry_t e;
    e.e_state = s; e.Unit = u; e.Dest = d; e.result = r; e.tag = t;
    e.speculative_tag = sp; e.A = a; e.Vk = v; e.rwmm = m;
    return e;
  endfunction

  task automatic step(string nm, bit rstn, bit ack, entry_t h0, entry_t h1,
                      logic [1:0] ret, logic [1:0] st, logic [1:0] we, bit req,
                      bit pay, logic [63:0] ir, bit c7 = 1'b0);
    exp_t e;
    @(posedge clk); #1;
    reset = rstn; mem_ack = ack; head[0] = h0; head[1] = h1;
    e.nm = nm; e.retire = ret; e.store = st; e.we = we;
    e.addr = {h1.Dest, h0.Dest};
    e.data = {h1.result, h0.result};
    e.tag  = {ret[1] ? h1.tag : 4'h0, ret[0] ? h0.tag : 4'h0};
    e.req = req; e.chk_pay = pay; e.maddr = pa; e.mwdata = pw; e.mmode = pm;
    e.ir = ir; e.chk_r7 = c7;
    q.push_back(e);
  endtask

  entry_t E, a3, a5, asp, a5b, st1, a4, st2, d7a, d7b, ldag, a0, st3;

  initial begin
    E    = mk(S_NOT_USED, ALU, 5'd0, 32'h0, 4'h0, 6'h0, 32'h0, 32'h0, BYTE);
    a3   = mk(S_EXECUTED, ALU, 5'd3, 32'h11, 4'h1, 6'h0, 32'h0, 32'h0, BYTE);
    a5   = mk(S_EXECUTED, ALU, 5'd5, 32'h22, 4'h2, 6'h0, 32'h0, 32'h0, BYTE);
    asp  = mk(S_EXECUTED, ALU, 5'd6, 32'h33, 4'h3, 6'b000010, 32'h0, 32'h0, BYTE);
    a5b  = mk(S_EXECUTED, ALU, 5'd8, 32'h34, 4'h4, 6'h0, 32'h0, 32'h0, BYTE);
    st1  = mk(S_EXECUTED, STORE, 5'd9, 32'h0, 4'h5, 6'h0, 32'h100, 32'hDEADBEEF, WORD);
    a4   = mk(S_EXECUTED, ALU, 5'd4, 32'h44, 4'h6, 6'h0, 32'h0, 32'h0, BYTE);
    st2  = mk(S_EXECUTED, STORE, 5'd0, 32'h0, 4'h7, 6'h0, 32'h200, 32'h55, HALF);
    d7a  = mk(S_EXECUTED, ALU, 5'd7, 32'h1, 4'h8, 6'h0, 32'h0, 32'h0, BYTE);
    d7b  = mk(S_EXECUTED, ALU, 5'd7, 32'h2, 4'h9, 6'h0, 32'h0, 32'h0, BYTE);
    ldag = mk(S_ADDR_GENERATED, LOAD, 5'd10, 32'h0, 4'hA, 6'h0, 32'h40, 32'h0, WORD);
    a0   = mk(S_EXECUTED, ALU, 5'd0, 32'h99, 4'hB, 6'h0, 32'h0, 32'h0, BYTE);
    st3  = mk(S_EXECUTED, STORE, 5'd0, 32'h0, 4'hC, 6'h0, 32'h300, 32'h77, BYTE);
    head[0] = E; head[1] = E;
    repeat (2) @(posedge clk);

    step("reset",     1, 0, E,   E,   2'b00, 2'b00, 2'b00, 0, 1, 64'd0);
    step("two_alu",   1, 0, a3,  a5,  2'b11, 2'b00, 2'b11, 0, 0, 64'd0);
    step("spec",      1, 0, asp, a5b, 2'b00, 2'b00, 2'b00, 0, 0, 64'd2);
    step("st_elig",   1, 0, st1, E,   2'b00, 2'b00, 2'b00, 0, 0, 64'd2);
    pa = 32'h100; pw = 32'hDEADBEEF; pm = WORD;
    step("st_wait1",  1, 0, st1, E,   2'b00, 2'b00, 2'b00, 1, 1, 64'd2);
    step("st_wait2",  1, 0, st1, E,   2'b00, 2'b00, 2'b00, 1, 1, 64'd2);
    step("st_wait3",  1, 0, st1, E,   2'b00, 2'b00, 2'b00, 1, 1, 64'd2);
    step("st_ack",    1, 1, st1, E,   2'b01, 2'b01, 2'b00, 1, 1, 64'd2);
    step("st_done",   1, 0, E,   E,   2'b00, 2'b00, 2'b00, 0, 0, 64'd3);
    step("alu_st",    1, 0, a4,  st2, 2'b01, 2'b00, 2'b01, 0, 0, 64'd3);
    step("st2_elig",  1, 0, st2, E,   2'b00, 2'b00, 2'b00, 0, 0, 64'd4);
    pa = 32'h200; pw = 32'h55; pm = HALF;
    step("st2_ack",   1, 1, st2, E,   2'b01, 2'b01, 2'b00, 1, 1, 64'd4);
    step("st2_done",  1, 0, E,   E,   2'b00, 2'b00, 2'b00, 0, 0, 64'd5);
    step("same_dest", 1, 0, d7a, d7b, 2'b11, 2'b00, 2'b11, 0, 0, 64'd5);
    step("r7",        1, 0, E,   E,   2'b00, 2'b00, 2'b00, 0, 0, 64'd7, 1'b1);
    step("ld_agen",   1, 1, ldag, a5, 2'b00, 2'b00, 2'b00, 0, 0, 64'd7);
    step("dest0",     1, 0, a0,  E,   2'b01, 2'b00, 2'b00, 0, 0, 64'd7);
    step("st3_elig",  1, 0, st3, E,   2'b00, 2'b00, 2'b00, 0, 0, 64'd8);
    pa = 32'h300; pw = 32'h77; pm = BYTE;
    step("st3_wait",  1, 0, st3, E,   2'b00, 2'b00, 2'b00, 1, 1, 64'd8);
    step("rst_in",    0, 0, st3, E,   2'b00, 2'b00, 2'b00, 1, 1, 64'd8);
    pa = 32'h0; pw = 32'h0; pm = BYTE;
    step("rst_out",   1, 1, st3, E,   2'b00, 2'b00, 2'b00, 0, 1, 64'd0);
    pa = 32'h300; pw = 32'h77; pm = BYTE;
    step("reissue",   1, 0, E,   E,   2'b00, 2'b00, 2'b00, 1, 1, 64'd0);
    step("ack_empty", 1, 1, E,   E,   2'b00, 2'b00, 2'b00, 1, 1, 64'd0);
    step("idle_end",  1, 0, E,   E,   2'b00, 2'b00, 2'b00, 0, 0, 64'd0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
